// File: rtl/dmem_store_buffered_responder.sv
// Data-memory responder: byte-addressed little-endian 64-bit word array fronted by a
// FIFO store buffer that drains on load-free cycles and forwards to younger loads.
module dmem_store_buffered_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int SB_DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               addressLoad,
    input  logic [63:0]               addressStore,
    input  logic                      read_enable,
    input  logic                      write_enable,
    input  logic [63:0]               write_data,
    input  logic [3:0]                xfer_size,
    output logic [63:0]               read_data,
    output logic                      read_valid,
    output logic                      store_ready,
    output logic [$clog2(SB_DEPTH):0] sb_count,
    output logic                      err_sticky
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    function automatic logic [7:0] size_bytes(input logic [3:0] sz);
        case (sz)
            4'd1:    size_bytes = 8'h01;
            4'd2:    size_bytes = 8'h03;
            4'd4:    size_bytes = 8'h0F;
            4'd8:    size_bytes = 8'hFF;
            default: size_bytes = 8'h00;
        endcase
    endfunction

    function automatic logic [63:0] size_bits(input logic [3:0] sz);
        case (sz)
            4'd1:    size_bits = 64'h0000_0000_0000_00FF;
            4'd2:    size_bits = 64'h0000_0000_0000_FFFF;
            4'd4:    size_bits = 64'h0000_0000_FFFF_FFFF;
            4'd8:    size_bits = 64'hFFFF_FFFF_FFFF_FFFF;
            default: size_bits = 64'h0000_0000_0000_0000;
        endcase
    endfunction

    // A zero byte mask doubles as "illegal size"; alignment uses the low offset bits.
    function automatic logic access_legal(input logic [63:0] addr, input logic [3:0] sz);
        logic [2:0] lsb_mask;
        case (sz)
            4'd2:    lsb_mask = 3'b001;
            4'd4:    lsb_mask = 3'b011;
            4'd8:    lsb_mask = 3'b111;
            default: lsb_mask = 3'b000;
        endcase
        access_legal = (size_bytes(sz) != 8'h00) &&
                       ((addr[2:0] & lsb_mask) == 3'b000) &&
                       (addr[63:3] < 61'(DEPTH_WORDS));
    endfunction

    logic [63:0]      mem_q [DEPTH_WORDS];
    logic [IDX_W-1:0] sb_idx_q  [SB_DEPTH];
    logic [63:0]      sb_data_q [SB_DEPTH];
    logic [7:0]       sb_mask_q [SB_DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;
    logic [63:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             err_q, err_d;

    logic             ld_legal_s, st_legal_s, push_s, pop_s;
    logic [IDX_W-1:0] ld_idx_s, st_idx_s;
    logic [63:0]      st_data_s, merged_s, ld_data_s;
    logic [7:0]       st_mask_s;

    // Request decode, arbitration and store-entry formatting.
    always_comb begin
        ld_legal_s = access_legal(addressLoad, xfer_size);
        st_legal_s = access_legal(addressStore, xfer_size);
        ld_idx_s   = addressLoad[3+IDX_W-1:3];
        st_idx_s   = addressStore[3+IDX_W-1:3];
        push_s     = write_enable & ready_q & st_legal_s;
        pop_s      = ~read_enable & (count_q != {CNT_W{1'b0}});
        st_data_s  = (write_data & size_bits(xfer_size)) << {addressStore[2:0], 3'b000};
        st_mask_s  = size_bytes(xfer_size) << addressStore[2:0];
    end

    // Load word: array data overlaid oldest-to-youngest so the youngest store wins.
    always_comb begin
        merged_s = mem_q[ld_idx_s];
        for (int i = 0; i < SB_DEPTH; i++) begin
            logic [PTR_W-1:0] slot;
            logic             hit;
            slot = head_q + PTR_W'(i);
            hit  = (CNT_W'(i) < count_q) && (sb_idx_q[slot] == ld_idx_s);
            for (int b = 0; b < 8; b++) begin
                merged_s[8*b +: 8] = (hit && sb_mask_q[slot][b]) ? sb_data_q[slot][8*b +: 8]
                                                                 : merged_s[8*b +: 8];
            end
        end
        ld_data_s = (merged_s >> {addressLoad[2:0], 3'b000}) & size_bits(xfer_size);
    end

    // Next-state for pointers, occupancy, load response and error flag.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        head_d  = pop_s  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push_s ? tail_q + PTR_W'(1) : tail_q;
        ready_d = (count_d < CNT_W'(SB_DEPTH));
        err_d   = err_q | (read_enable & ~ld_legal_s) |
                  (write_enable & ~(ready_q & st_legal_s));
        if (read_enable) begin
            rvalid_d = 1'b1;
            rdata_d  = ld_legal_s ? ld_data_s : 64'h0;
        end else begin
            rvalid_d = 1'b0;
            rdata_d  = rdata_q;
        end
    end

    // Control state with asynchronous reset; in-flight stores are discarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q   <= {PTR_W{1'b0}};
            tail_q   <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            ready_q  <= 1'b1;
            rdata_q  <= 64'h0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Buffer payload and array storage; neither needs reset since occupancy gates use.
    always_ff @(posedge clk) begin
        if (push_s) begin
            sb_idx_q[tail_q]  <= st_idx_s;
            sb_data_q[tail_q] <= st_data_s;
            sb_mask_q[tail_q] <= st_mask_s;
        end
        if (pop_s) begin
            for (int b = 0; b < 8; b++) begin
                if (sb_mask_q[head_q][b]) begin
                    mem_q[sb_idx_q[head_q]][8*b +: 8] <= sb_data_q[head_q][8*b +: 8];
                end
            end
        end
    end

    assign read_data   = rdata_q;
    assign read_valid  = rvalid_q;
    assign store_ready = ready_q;
    assign sb_count    = count_q;
    assign err_sticky  = err_q;

endmodule
